dmem_port_arbiter: RTL and testbench

//  Sequences and shares the single-port data memory between two requesters: core load/store (C) and debug/DMA (D).

---
 rtl/dmem_port_arbiter_pkg.sv | 21 ++
 rtl/dmem_port_arbiter_if.sv | 17 +
 rtl/dmem_port_arbiter_pick.sv | 35 +++
 rtl/dmem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM state encodings, requester IDs and the default memory depth.
package dmem_port_arbiter_pkg;

   localparam int DMEM_DEPTH = 256;

   typedef enum logic {
      ARB_INIT = 1'b0,
      ARB_RUN  = 1'b1
   } arb_state_t;

   typedef enum logic {
      ARB_ID_C = 1'b0,
      ARB_ID_D = 1'b1
   } arb_id_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side request/response bundle for one data-memory requester.
// The requester drives the master side; the arbiter owns the slave side.
interface dmem_req_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (output valid, we, addr, wdata, input ready, rsp_valid, rsp_rdata);
   modport slave  (input valid, we, addr, wdata, output ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/dmem_port_arbiter_pick.sv
// Two-input grant logic for the core (C) and debug/DMA (D) requesters.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise C has fixed priority and last_grant is ignored.
module dmem_arb_pick
   import dmem_port_arbiter_pkg::*;
(
   input  logic    c_valid,
   input  logic    d_valid,
   input  arb_id_t last_grant,
   output logic    grant_c,
   output logic    grant_d
);

   always_comb begin
      grant_c = 1'b0;
      grant_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
      if (c_valid && d_valid) begin
         grant_c = (last_grant == ARB_ID_D);
         grant_d = !grant_c;
      end else begin
         grant_c = c_valid;
         grant_d = d_valid;
      end
`else
      grant_c = c_valid;
      grant_d = d_valid && !c_valid;
`endif
   end

`ifndef DMEM_ARB_RR_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Clears the single-port data memory after reset, then arbitrates one C/D access per cycle.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration (default is C-over-D priority).
//
// state    | meaning
// ARB_INIT | clear-walk: write zero to words 0..DEPTH-1, requesters held off
// ARB_RUN  | normal operation, one granted access per cycle
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = DMEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   dmem_req_if.slave         c_bus,
   dmem_req_if.slave         d_bus,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              init_done
);

   localparam int                PTR_W    = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [PTR_W-1:0]  clr_ptr;
   logic              run;
   logic              grant_c;
   logic              grant_d;
   arb_id_t           last_grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_in_range;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic              c_rsp_q;
   logic              d_rsp_q;
   logic [DATA_W-1:0] c_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) state <= ARB_INIT;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset)                  clr_ptr <= '0;
      else if (state == ARB_INIT) clr_ptr <= clr_ptr + 1'b1;
   end

   always_comb begin
      state_nxt = state;
      if (state == ARB_INIT && clr_ptr == LAST_PTR) state_nxt = ARB_RUN;
   end

   assign run = (state == ARB_RUN) && !reset;

   dmem_arb_pick u_pick (
      .c_valid    (c_bus.valid && run),
      .d_valid    (d_bus.valid && run),
      .last_grant (last_grant),
      .grant_c    (grant_c),
      .grant_d    (grant_d)
   );

`ifdef DMEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset)        last_grant <= ARB_ID_D;
      else if (grant_c) last_grant <= ARB_ID_C;
      else if (grant_d) last_grant <= ARB_ID_D;
   end
`else
   assign last_grant = ARB_ID_D;
`endif

   always_comb begin
      sel_we    = c_bus.we;
      sel_addr  = c_bus.addr;
      sel_wdata = c_bus.wdata;
      if (grant_d) begin
         sel_we    = d_bus.we;
         sel_addr  = d_bus.addr;
         sel_wdata = d_bus.wdata;
      end
   end

   assign sel_in_range = (sel_addr < DEPTH_A);

   always_comb begin
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      c_bus.ready = 1'b0;
      d_bus.ready = 1'b0;
      init_done   = 1'b0;
      if (!reset) begin
         case (state)
            ARB_INIT: begin
               mem_we   = 1'b1;
               mem_addr = ADDR_W'(clr_ptr);
            end
            ARB_RUN: begin
               init_done   = 1'b1;
               c_bus.ready = grant_c;
               d_bus.ready = grant_d;
               // out-of-range writes still complete but must never reach the array
               if (grant_c || grant_d) begin
                  mem_we    = sel_we && sel_in_range;
                  mem_addr  = sel_addr;
                  mem_wdata = sel_wdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_rdata_nxt = (!sel_we && sel_in_range) ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         c_rsp_q   <= 1'b0;
         d_rsp_q   <= 1'b0;
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         c_rsp_q   <= grant_c;
         d_rsp_q   <= grant_d;
         c_rdata_q <= grant_c ? rsp_rdata_nxt : '0;
         d_rdata_q <= grant_d ? rsp_rdata_nxt : '0;
      end
   end

   // a response registered just before reset must not be seen during reset
   assign c_bus.rsp_valid = c_rsp_q && !reset;
   assign d_bus.rsp_valid = d_rsp_q && !reset;
   assign c_bus.rsp_rdata = reset ? '0 : c_rdata_q;
   assign d_bus.rsp_rdata = reset ? '0 : d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed C/D traffic over a 16-word memory model,
// checked every cycle against an access-level reference model plus literal expectations.
module tb_dmem_port_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int IW    = $clog2(DEPTH);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) c_bus ();
   dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();

   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          init_done;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .c_bus     (c_bus),
      .d_bus     (d_bus),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .init_done (init_done)
   );

   logic [DW-1:0] dmem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) dmem[i] = 32'hFFFF_FFFF;
   assign mem_rdata = (mem_addr < DEPTH) ? dmem[mem_addr[IW-1:0]] : 32'hBAD0_BAD0;
   always @(posedge clk) if (mem_we && mem_addr < DEPTH) dmem[mem_addr[IW-1:0]] <= mem_wdata;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: access-level view of the port (walk index, word array, pending responses)
   bit            m_run = 0;
   int            m_ptr = 0;
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_last_d = 1;
   bit            pc_v = 0, pd_v = 0;
   logic [DW-1:0] pc_d = '0, pd_d = '0;

   always @(negedge clk) begin : model_cmp
      int            win;
      logic          w_we, inr;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_wdata, rd;
      if (reset) begin
         check("rst_c_ready", c_bus.ready, 0);
         check("rst_d_ready", d_bus.ready, 0);
         check("rst_mem_we", mem_we, 0);
         check("rst_init_done", init_done, 0);
         check("rst_c_rsp", c_bus.rsp_valid, 0);
         check("rst_d_rsp", d_bus.rsp_valid, 0);
         m_run = 0; m_ptr = 0; pc_v = 0; pd_v = 0; m_last_d = 1;
      end else if (!m_run) begin
         check("walk_init_done", init_done, 0);
         check("walk_c_ready", c_bus.ready, 0);
         check("walk_d_ready", d_bus.ready, 0);
         check("walk_mem_we", mem_we, 1);
         check("walk_addr", mem_addr, m_ptr);
         check("walk_wdata", mem_wdata, 0);
         check("walk_c_rsp", c_bus.rsp_valid, 0);
         check("walk_d_rsp", d_bus.rsp_valid, 0);
         m_mem[m_ptr] = '0;
         m_ptr++;
         if (m_ptr == DEPTH) m_run = 1;
         pc_v = 0; pd_v = 0;
      end else begin
         check("run_init_done", init_done, 1);
         check("c_rsp_valid", c_bus.rsp_valid, pc_v);
         check("d_rsp_valid", d_bus.rsp_valid, pd_v);
         if (pc_v) check("c_rsp_rdata", c_bus.rsp_rdata, pc_d);
         if (pd_v) check("d_rsp_rdata", d_bus.rsp_rdata, pd_d);
         win = -1;
         if (c_bus.valid && d_bus.valid) begin
`ifdef DMEM_ARB_RR_EN
            win = m_last_d ? 0 : 1;
`else
            win = 0;
`endif
         end else if (c_bus.valid) win = 0;
         else if (d_bus.valid) win = 1;
         check("c_ready", c_bus.ready, win == 0);
         check("d_ready", d_bus.ready, win == 1);
         pc_v = 0; pd_v = 0;
         if (win >= 0) begin
            w_we    = (win == 0) ? c_bus.we    : d_bus.we;
            w_addr  = (win == 0) ? c_bus.addr  : d_bus.addr;
            w_wdata = (win == 0) ? c_bus.wdata : d_bus.wdata;
            inr     = (w_addr < DEPTH);
            check("mem_we", mem_we, w_we && inr);
            check("mem_addr", mem_addr, w_addr);
            if (w_we && inr) check("mem_wdata", mem_wdata, w_wdata);
            rd = (!w_we && inr) ? m_mem[w_addr[IW-1:0]] : '0;
            if (w_we && inr) m_mem[w_addr[IW-1:0]] = w_wdata;
            if (win == 0) begin pc_v = 1; pc_d = rd; end
            else          begin pd_v = 1; pd_d = rd; end
            m_last_d = (win == 1);
         end else begin
            check("idle_mem_we", mem_we, 0);
         end
      end
   end

   task automatic req(input bit is_d, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, output logic we_seen);
      bit ok = 0;
      we_seen = 1'bx;
      if (is_d) begin d_bus.valid = 1; d_bus.we = we; d_bus.addr = addr; d_bus.wdata = wdata; end
      else      begin c_bus.valid = 1; c_bus.we = we; c_bus.addr = addr; c_bus.wdata = wdata; end
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if ((is_d ? d_bus.ready : c_bus.ready) === 1'b1) begin
            ok = 1; we_seen = mem_we; break;
         end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL req_timeout: got no ready expected ready within 64 cycles (d=%0d addr=%0h)", is_d, addr);
      end
      @(posedge clk); #1;
      if (is_d) d_bus.valid = 0; else c_bus.valid = 0;
   endtask

   initial begin : stim
      logic       ws;
      int         walk, k;
      bit         seen;
      logic [3:0] gseq;
      c_bus.valid = 0; c_bus.we = 0; c_bus.addr = '0; c_bus.wdata = '0;
      d_bus.valid = 0; d_bus.we = 0; d_bus.addr = '0; d_bus.wdata = '0;
      reset = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;

      // clear-walk length and post-clear reads
      walk = 0; seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (init_done) begin seen = 1; break; end
         if (mem_we) walk++;
      end
      check("walk_done_seen", seen, 1);
      check("walk_len", walk, 16);
      @(posedge clk); #1;
      req(0, 0, 0, '0, ws);
      @(negedge clk);
      check("clr_rd0_valid", c_bus.rsp_valid, 1);
      check("clr_rd0_data", c_bus.rsp_rdata, 32'h0);
      @(posedge clk); #1;
      req(0, 0, 15, '0, ws);
      @(negedge clk);
      check("clr_rd15_data", c_bus.rsp_rdata, 32'h0);
      @(posedge clk); #1;

      // write then same-address read back-to-back
      req(0, 1, 5, 32'hDEAD_BEEF, ws);
      check("wr5_mem_we", ws, 1);
      req(0, 0, 5, '0, ws);
      @(negedge clk);
      check("rd5_valid", c_bus.rsp_valid, 1);
      check("rd5_data", c_bus.rsp_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;

      // out-of-range D write: completes, no memory write, no aliasing into word 12
      req(1, 1, 300, 32'h1234_5678, ws);
      check("oor_mem_we", ws, 0);
      @(negedge clk);
      check("oor_rsp_valid", d_bus.rsp_valid, 1);
      check("oor_rsp_data", d_bus.rsp_rdata, 32'h0);
      @(posedge clk); #1;
      req(1, 1, 7, 32'h7777_7777, ws);
      req(1, 0, 12, '0, ws);
      @(negedge clk);
      check("alias12_data", d_bus.rsp_rdata, 32'h0);
      @(posedge clk); #1;

      // contention for 4 cycles, last grant was D
      c_bus.valid = 1; c_bus.we = 0; c_bus.addr = 5;
      d_bus.valid = 1; d_bus.we = 0; d_bus.addr = 7;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         gseq[i] = d_bus.ready;
      end
      @(posedge clk); #1;
      c_bus.valid = 0; d_bus.valid = 0;
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      check("grant_seq", gseq, 4'b1010);
      check("tie_last_d_data", d_bus.rsp_rdata, 32'h7777_7777);
`else
      check("grant_seq", gseq, 4'b0000);
      check("tie_last_c_data", c_bus.rsp_rdata, 32'hDEAD_BEEF);
`endif
      @(posedge clk); #1;

      // reset one cycle after a read transfer, C held valid through the new walk
      req(0, 0, 5, '0, ws);
      reset = 1;
      @(negedge clk);
      check("rst_drop_rsp", c_bus.rsp_valid, 0);
      @(posedge clk); #1;
      reset = 0;
      c_bus.valid = 1; c_bus.we = 0; c_bus.addr = 5;
      k = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 0) check("rewalk_addr0", mem_addr, 0);
         if (c_bus.ready) begin k = i; break; end
      end
      check("held_accept_cycle", k, 16);
      @(posedge clk); #1;
      c_bus.valid = 0;
      @(negedge clk);
      check("rewalk_rd5_data", c_bus.rsp_rdata, 32'h0);
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
